// File: rtl/ctrl_seq.sv
// -----------------------------------------------------------------------------
// ctrl_seq -- multi-cycle control sequencer for the register-file/ALU datapath.
//
// Fetches one RV32 instruction at a time over a req/ack handshake, decodes it,
// and drives the datapath control lines for one EXEC cycle. It owns the PC and
// resolves beq/bne from the ALU EQ flag. Supported: addi, add, sub, beq, bne.
// Any other encoding, or a taken branch to a target with bit 1 set, parks the
// sequencer in HALT until reset.
//
// Sequence per instruction: FETCH (>=1 cycle) -> DECODE (1) -> EXEC (1).
//
// Optional feature: define CTRL_SEQ_RETIRE_CNT_EN to add the retire_cnt output,
// a 32-bit count of instructions that finished EXEC without halting.
//
// Ports
//   clk         in   1          clock, rising edge
//   rst         in   1          asynchronous active-high reset
//   fetch_req   out  1          instruction request at pc (FETCH only)
//   pc          out  PC_WIDTH   fetch address
//   fetch_ack   in   1          instr valid; completes the fetch
//   instr       in   32         instruction word, sampled with fetch_ack
//   rs1/rs2/rd  out  5 each     datapath register addresses
//   ImmOp       out  32         sign-extended immediate
//   ALUsrc      out  1          1 = op2 is ImmOp, 0 = rs2
//   ALUctrl     out  3          000 add, 001 sub
//   RegWrite    out  1          register write enable (EXEC only)
//   EQ          in   1          ALU equality flag, used in EXEC
//   halted      out  1          sticky halt indicator
//   retire_cnt  out  32         retired instruction count (optional)
// -----------------------------------------------------------------------------
module ctrl_seq #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  PC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                fetch_req,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                fetch_ack,
    input  logic [31:0]         instr,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [31:0]         ImmOp,
    output logic                ALUsrc,
    output logic [2:0]          ALUctrl,
    output logic                RegWrite,
    input  logic                EQ,
    output logic                halted
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]         retire_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t                r_state;
    state_t                w_state_next;

    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_next;
    logic [31:0]           r_instr;
    logic [4:0]            r_rs1;
    logic [4:0]            r_rs2;
    logic [4:0]            r_rd;
    logic [31:0]           r_imm;
    logic                  r_alusrc;
    logic [2:0]            r_aluctrl;
    logic                  r_wr_en;
    logic                  r_is_br;
    logic                  r_is_bne;
    logic                  r_halted;

    logic                  w_load_instr;
    logic                  w_load_fields;

    // ---------------------------------------------------------------------
    // Decode of the latched instruction word
    // ---------------------------------------------------------------------
    logic [6:0]            w_opc;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic [31:0]           w_imm_i;
    logic [31:0]           w_imm_b;

    logic                  w_legal;
    logic [31:0]           w_dec_imm;
    logic                  w_dec_alusrc;
    logic [2:0]            w_dec_aluctrl;
    logic                  w_dec_wr;
    logic                  w_dec_br;
    logic                  w_dec_bne;

    assign w_opc   = r_instr[6:0];
    assign w_f3    = r_instr[14:12];
    assign w_f7    = r_instr[31:25];
    assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                      r_instr[30:25], r_instr[11:8], 1'b0};

    always_comb begin
        w_legal       = 1'b0;
        w_dec_imm     = '0;
        w_dec_alusrc  = 1'b0;
        w_dec_aluctrl = ALU_ADD;
        w_dec_wr      = 1'b0;
        w_dec_br      = 1'b0;
        w_dec_bne     = 1'b0;
        case (w_opc)
            OPC_OPIMM: begin
                if (w_f3 == 3'b000) begin
                    w_legal      = 1'b1;
                    w_dec_imm    = w_imm_i;
                    w_dec_alusrc = 1'b1;
                    w_dec_wr     = 1'b1;
                end
            end
            OPC_OP: begin
                if (w_f3 == 3'b000 && w_f7 == 7'b0000000) begin
                    w_legal  = 1'b1;
                    w_dec_wr = 1'b1;
                end else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) begin
                    w_legal       = 1'b1;
                    w_dec_aluctrl = ALU_SUB;
                    w_dec_wr      = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // Branches compare rs1/rs2 through a subtract so EQ is valid.
                if (w_f3 == 3'b000 || w_f3 == 3'b001) begin
                    w_legal       = 1'b1;
                    w_dec_imm     = w_imm_b;
                    w_dec_aluctrl = ALU_SUB;
                    w_dec_br      = 1'b1;
                    w_dec_bne     = w_f3[0];
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Branch resolution and next-PC arithmetic (wraps mod 2^PC_WIDTH)
    // ---------------------------------------------------------------------
    logic [PC_WIDTH-1:0]   w_imm_pc;
    logic [PC_WIDTH-1:0]   w_target;
    logic [PC_WIDTH-1:0]   w_pc_seq;
    logic                  w_taken;
    logic                  w_misaligned;

    assign w_imm_pc     = PC_WIDTH'($signed(r_imm));
    assign w_target     = r_pc + w_imm_pc;
    assign w_pc_seq     = r_pc + PC_WIDTH'(4);
    assign w_taken      = r_is_br && (EQ ^ r_is_bne);
    assign w_misaligned = w_taken && w_target[1];

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_load_instr  = 1'b0;
        w_load_fields = 1'b0;
        fetch_req     = 1'b0;
        RegWrite      = 1'b0;
        case (r_state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    w_load_instr = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // An illegal word halts, so its fields are never presented.
                if (w_legal) begin
                    w_load_fields = 1'b1;
                    w_state_next  = S_EXEC;
                end else begin
                    w_state_next  = S_HALT;
                end
            end
            S_EXEC: begin
                RegWrite = r_wr_en && (r_rd != 5'd0);
                if (w_misaligned) begin
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_FETCH;
                    w_pc_next    = w_taken ? w_target : w_pc_seq;
                end
            end
            S_HALT: ;
            default: w_state_next = S_FETCH;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= PC_RESET;
            r_instr   <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_imm     <= '0;
            r_alusrc  <= 1'b0;
            r_aluctrl <= ALU_ADD;
            r_wr_en   <= 1'b0;
            r_is_br   <= 1'b0;
            r_is_bne  <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_load_instr) begin
                r_instr <= instr;
            end
            if (w_load_fields) begin
                r_rs1     <= r_instr[19:15];
                r_rs2     <= r_instr[24:20];
                r_rd      <= r_instr[11:7];
                r_imm     <= w_dec_imm;
                r_alusrc  <= w_dec_alusrc;
                r_aluctrl <= w_dec_aluctrl;
                r_wr_en   <= w_dec_wr;
                r_is_br   <= w_dec_br;
                r_is_bne  <= w_dec_bne;
            end
            if (w_state_next == S_HALT) begin
                r_halted <= 1'b1;
            end
        end
    end

`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;
    logic        w_retire_inc;

    assign w_retire_inc = (r_state == S_EXEC) && !w_misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_retire_inc) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

    assign pc      = r_pc;
    assign rs1     = r_rs1;
    assign rs2     = r_rs2;
    assign rd      = r_rd;
    assign ImmOp   = r_imm;
    assign ALUsrc  = r_alusrc;
    assign ALUctrl = r_aluctrl;
    assign halted  = r_halted;

endmodule

// File: tb/tb_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_ctrl_seq -- self-checking bench for ctrl_seq.
//
// A behavioural model (instruction-level: decode by field arithmetic, next PC
// by integer addition) tracks pc/halted/retire count and what the control
// outputs must be in each cycle. One compare process checks the DUT against it
// on every falling edge; a few literal expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] pc;
    logic        fetch_ack;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] ImmOp;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic        RegWrite;
    logic        EQ;
    logic        halted;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    ctrl_seq #(
        .PC_WIDTH (32),
        .PC_RESET (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .pc        (pc),
        .fetch_ack (fetch_ack),
        .instr     (instr),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .ImmOp     (ImmOp),
        .ALUsrc    (ALUsrc),
        .ALUctrl   (ALUctrl),
        .RegWrite  (RegWrite),
        .EQ        (EQ),
        .halted    (halted)
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    // ---------------- model state and per-cycle expectations ----------------
    logic [31:0] m_pc;
    bit          m_halted;
    int unsigned m_retire;

    bit          e_fetch_req;
    bit          e_regwrite;
    bit          e_exec;
    bit          e_imm_chk;
    logic [4:0]  e_rd;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [31:0] e_imm;
    bit          e_alusrc;
    logic [2:0]  e_aluctrl;

    logic        cap_rw;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("RegWrite", {31'd0, RegWrite}, {31'd0, e_regwrite});
        if (!rst) chk("fetch_req", {31'd0, fetch_req}, {31'd0, e_fetch_req});
        if (e_exec) begin
            chk("rd", {27'd0, rd}, {27'd0, e_rd});
            chk("rs1", {27'd0, rs1}, {27'd0, e_rs1});
            chk("rs2", {27'd0, rs2}, {27'd0, e_rs2});
            chk("ALUsrc", {31'd0, ALUsrc}, {31'd0, e_alusrc});
            chk("ALUctrl", {29'd0, ALUctrl}, {29'd0, e_aluctrl});
            if (e_imm_chk) chk("ImmOp", ImmOp, e_imm);
        end
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_retire);
`endif
    end

    // ---------------- model decode (kind: 0 addi 1 add 2 sub 3 beq 4 bne) ----
    task automatic model_decode(input logic [31:0] w, output bit legal,
                                output int kind, output int imm);
        int opc;
        int f3;
        int f7;
        opc   = int'(w[6:0]);
        f3    = int'(w[14:12]);
        f7    = int'(w[31:25]);
        legal = 1'b0;
        kind  = -1;
        imm   = 0;
        if (opc == 'h13 && f3 == 0) begin
            legal = 1'b1; kind = 0;
            imm = int'(w[31:20]);
            if (imm >= 2048) imm -= 4096;
        end else if (opc == 'h33 && f3 == 0 && f7 == 0) begin
            legal = 1'b1; kind = 1;
        end else if (opc == 'h33 && f3 == 0 && f7 == 'h20) begin
            legal = 1'b1; kind = 2;
        end else if (opc == 'h63 && (f3 == 0 || f3 == 1)) begin
            legal = 1'b1; kind = 3 + f3;
            imm = 4096 * int'(w[31]) + 2048 * int'(w[7])
                + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
            if (w[31]) imm -= 8192;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction: `waits` idle FETCH cycles, ack, DECODE, EXEC.
    task automatic run(input logic [31:0] w, input int waits, input bit eq);
        bit          legal;
        int          kind;
        int          imm;
        bit          taken;
        logic [31:0] tgt;
        logic [31:0] pc0;
        model_decode(w, legal, kind, imm);
        pc0        = m_pc;
        e_exec     = 1'b0;
        e_regwrite = 1'b0;
        for (int i = 0; i < waits; i++) begin
            fetch_ack = 1'b0; instr = $urandom; e_fetch_req = 1'b1;
            step();
        end
        fetch_ack = 1'b1; instr = w; e_fetch_req = 1'b1;
        step();
        // DECODE: a stray ack with junk data must be ignored
        fetch_ack = 1'b1; instr = $urandom; e_fetch_req = 1'b0;
        step();
        fetch_ack = 1'b0;
        if (!legal) begin
            m_halted    = 1'b1;
            e_fetch_req = 1'b0;
            $display("instr %h at pc %h: illegal -> halt", w, pc0);
            return;
        end
        // EXEC
        EQ         = eq;
        e_exec     = 1'b1;
        e_rd       = w[11:7];
        e_rs1      = w[19:15];
        e_rs2      = w[24:20];
        e_alusrc   = (kind == 0);
        e_aluctrl  = (kind <= 1) ? 3'd0 : 3'd1;
        e_imm_chk  = (kind == 0 || kind >= 3);
        e_imm      = 32'(imm);
        e_regwrite = (kind <= 2) && (w[11:7] != 5'd0);
        @(negedge clk);
        cap_rw = RegWrite;
        step();
        EQ         = 1'b0;
        e_exec     = 1'b0;
        e_regwrite = 1'b0;
        taken = (kind == 3 && eq) || (kind == 4 && !eq);
        tgt   = m_pc + 32'(imm);
        if (taken && (tgt % 4) != 0) begin
            m_halted = 1'b1;
        end else begin
            m_pc = taken ? tgt : m_pc + 32'd4;
            m_retire++;
        end
        e_fetch_req = !m_halted;
        $display("instr %h at pc %h eq=%0b waits=%0d -> pc %h halted=%0b",
                 w, pc0, eq, waits, m_pc, m_halted);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            fetch_ack = 1'($urandom_range(0, 1));
            instr     = $urandom;
            step();
        end
        fetch_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_ack = 1'b0; EQ = 1'b0;
        m_pc = 32'h0; m_halted = 1'b0; m_retire = 0;
        e_exec = 1'b0; e_regwrite = 1'b0; e_fetch_req = 1'b1;
        step();
        step();
        rst = 1'b0;
        $display("reset released, pc %h", m_pc);
    endtask

    initial begin
        rst = 1'b1; fetch_ack = 1'b0; instr = '0; EQ = 1'b0;
        m_pc = 32'h0; m_halted = 1'b0; m_retire = 0;
        e_exec = 1'b0; e_regwrite = 1'b0; e_fetch_req = 1'b1; e_imm_chk = 1'b0;
        e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_alusrc = 1'b0; e_aluctrl = '0;
        cap_rw = 1'b0;
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ALUctrl", {29'd0, ALUctrl}, 32'd0);
        chk("rst_ImmOp", ImmOp, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_ALUsrc", {31'd0, ALUsrc}, 32'd0);
        step();
        rst = 1'b0;
        $display("reset released, pc %h", m_pc);

        run(32'h00700293, 0, 1'b0);           // addi x5,x0,7
        chk("lit_addi_rw", {31'd0, cap_rw}, 32'd1);
        chk("lit_addi_rd", {27'd0, rd}, 32'd5);
        chk("lit_addi_imm", ImmOp, 32'd7);
        chk("lit_addi_alusrc", {31'd0, ALUsrc}, 32'd1);
        chk("lit_addi_pc", pc, 32'h4);
        run(32'h00208033, 0, 1'b0);           // add x0,x1,x2
        chk("lit_add_x0_rw", {31'd0, cap_rw}, 32'd0);
        chk("lit_add_pc", pc, 32'h8);
        run(32'h402081B3, 0, 1'b0);           // sub x3,x1,x2
        chk("lit_sub_aluctrl", {29'd0, ALUctrl}, 32'd1);
        run(32'hFFF00093, 0, 1'b0);           // addi x1,x0,-1
        chk("lit_neg_imm", ImmOp, 32'hFFFF_FFFF);
        chk("lit_pc_10", pc, 32'h10);
        run(32'hFE209CE3, 0, 1'b0);           // bne -8, EQ=0 -> taken
        chk("lit_bne_taken_pc", pc, 32'h08);
        run(32'h00700293, 0, 1'b0);
        run(32'h00700293, 0, 1'b0);
        run(32'hFE209CE3, 0, 1'b1);           // bne -8, EQ=1 -> not taken
        chk("lit_bne_fall_pc", pc, 32'h14);
        run(32'h00000463, 0, 1'b1);           // beq +8 taken
        chk("lit_beq_pc", pc, 32'h1C);
        run(32'h00528333, 5, 1'b0);           // add x6,x5,x5 with 5 wait cycles
        chk("lit_wait_pc", pc, 32'h20);
        run(32'hFC000EE3, 0, 1'b1);           // beq -36 -> 0xFFFFFFFC
        chk("lit_top_pc", pc, 32'hFFFF_FFFC);
        run(32'h00700293, 0, 1'b0);           // wraps to 0
        chk("lit_wrap_pc", pc, 32'h0);
        run(32'h00001363, 0, 1'b1);           // bne +6 not taken: no halt
        chk("lit_odd_fall_halted", {31'd0, halted}, 32'd0);
        run(32'h00000363, 0, 1'b1);           // beq +6 taken: misaligned
        idle(6);
        chk("lit_misalign_halted", {31'd0, halted}, 32'd1);
        chk("lit_misalign_pc", pc, 32'h4);

        do_reset();
        run(32'h00700293, 0, 1'b0);
        // reset asserted in the middle of DECODE
        fetch_ack = 1'b1; instr = 32'h00700293; e_fetch_req = 1'b1;
        step();
        fetch_ack = 1'b0;
        rst = 1'b1; m_pc = 32'h0; m_halted = 1'b0; m_retire = 0; e_regwrite = 1'b0;
        step();
        rst = 1'b0; e_fetch_req = 1'b1;
        $display("reset during DECODE, pc %h", m_pc);
        step();
        chk("lit_midrst_pc", pc, 32'h0);
        chk("lit_midrst_rw", {31'd0, RegWrite}, 32'd0);
        chk("lit_midrst_req", {31'd0, fetch_req}, 32'd1);

        run(32'h00700293, 0, 1'b0);
        run(32'hFFFF_FFFF, 0, 1'b0);          // illegal
        idle(6);
        chk("lit_illegal_halted", {31'd0, halted}, 32'd1);
        chk("lit_illegal_req", {31'd0, fetch_req}, 32'd0);
        chk("lit_illegal_pc", pc, 32'h4);
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        chk("lit_illegal_retire", retire_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
